tm1638_arbiter: RTL and testbench

Round-robin arbiter sharing one TM1638 driver command port among NUM_CLIENTS requesters (score display, LED status, button poller, ...). Each client posts a single segment-write, LED-write or button-read transaction; the arbiter grants one at a time, runs the driver READY/strobe handshake, and returns a one-cycle ACK (plus button data for reads). Sits between the application blocks and the TM1638 serial driver, replacing per-client direct strobing.

---
 rtl/tm1638_pkg.sv | 33 +++
 rtl/tm1638_arbiter_if.sv | 34 +++
 rtl/tm1638_rr_pick.sv | 28 ++
 rtl/tm1638_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_tm1638_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tm1638_pkg.sv
// rtl/tm1638_pkg.sv - shared op encodings, FSM states and strobe selects for the TM1638 arbiter
package tm1638_pkg;

    typedef enum logic [1:0] {
        OP_WR_SEG = 2'b00,
        OP_WR_LED = 2'b01,
        OP_RD_BTN = 2'b10,
        OP_RSVD   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

    // Strobe vector layout: {READ_BUTTON, WRITE_LED, WRITE_SEG}
    localparam logic [2:0] STB_NONE = 3'b000;
    localparam logic [2:0] STB_SEG  = 3'b001;
    localparam logic [2:0] STB_LED  = 3'b010;
    localparam logic [2:0] STB_BTN  = 3'b100;

    function automatic logic [2:0] op_to_strobe(input op_e op);
        case (op)
            OP_WR_SEG: return STB_SEG;
            OP_WR_LED: return STB_LED;
            OP_RD_BTN: return STB_BTN;
            default:   return STB_NONE;
        endcase
    endfunction

endpackage

// File: rtl/tm1638_arbiter_if.sv
// rtl/tm1638_arbiter_if.sv - client request/ack bus plus TM1638 driver command port
interface tm1638_arbiter_if #(
    parameter int NUM_CLIENTS = 4
);
    logic [NUM_CLIENTS-1:0]   REQ;
    logic [2*NUM_CLIENTS-1:0] REQ_OP;
    logic [3*NUM_CLIENTS-1:0] REQ_INDEX;
    logic [4*NUM_CLIENTS-1:0] REQ_DATA;
    logic [NUM_CLIENTS-1:0]   ACK;
    logic [7:0]               RD_DATA;
    logic                     ERR;
    logic                     BUSY;
    logic                     READY;
    logic                     WRITE_SEG;
    logic                     WRITE_LED;
    logic                     READ_BUTTON;
    logic [2:0]               SEG_INDEX;
    logic [3:0]               SEG_DATA;
    logic [7:0]               BUTTONS;

    // Arbiter side
    modport slave (
        input  REQ, REQ_OP, REQ_INDEX, REQ_DATA, READY, BUTTONS,
        output ACK, RD_DATA, ERR, BUSY, WRITE_SEG, WRITE_LED, READ_BUTTON,
               SEG_INDEX, SEG_DATA
    );

    // Clients plus driver side
    modport master (
        output REQ, REQ_OP, REQ_INDEX, REQ_DATA, READY, BUTTONS,
        input  ACK, RD_DATA, ERR, BUSY, WRITE_SEG, WRITE_LED, READ_BUTTON,
               SEG_INDEX, SEG_DATA
    );
endinterface

// File: rtl/tm1638_rr_pick.sv
// rtl/tm1638_rr_pick.sv - combinational round-robin picker: first requester after last_grant
module tm1638_rr_pick #(
    parameter int NUM_CLIENTS = 4,
    parameter int IDX_W       = $clog2(NUM_CLIENTS)
) (
    input  logic [NUM_CLIENTS-1:0] req_in,
    input  logic [IDX_W-1:0]       last_grant,
    output logic [IDX_W-1:0]       winner,
    output logic                   valid
);

    logic [IDX_W-1:0] idx;

    // Walk the ring starting one past the previous grant; first hit wins
    always_comb begin
        winner = last_grant;
        valid  = 1'b0;
        idx    = last_grant;
        for (int k = 0; k < NUM_CLIENTS; k++) begin
            idx = (idx == IDX_W'(NUM_CLIENTS - 1)) ? '0 : idx + 1'b1;
            if (!valid && req_in[idx]) begin
                valid  = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/tm1638_arbiter.sv
// rtl/tm1638_arbiter.sv - round-robin sharing of one TM1638 driver port; TM1638_ARB_TIMEOUT_EN adds a watchdog
module tm1638_arbiter
    import tm1638_pkg::*;
#(
    parameter int NUM_CLIENTS    = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic            CLK_IN,
    input  logic            RST_IN,
    tm1638_arbiter_if.slave bus
);

    localparam int               IDX_W      = $clog2(NUM_CLIENTS);
    localparam logic [IDX_W-1:0] LAST_RESET = IDX_W'(NUM_CLIENTS - 1);

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       last_grant_q, last_grant_d;
    logic [IDX_W-1:0]       winner_q, winner_d;
    op_e                    op_q, op_d;
    logic [2:0]             seg_index_q, seg_index_d;
    logic [3:0]             seg_data_q, seg_data_d;
    logic [2:0]             strobe_q, strobe_d;
    logic [NUM_CLIENTS-1:0] ack_q, ack_d;
    logic                   err_q, err_d;
    logic [7:0]             rd_data_q, rd_data_d;

    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_valid;
    logic [1:0]             pick_op;
    logic [2:0]             pick_index;
    logic [3:0]             pick_data;
    logic                   timeout_hit;

    tm1638_rr_pick #(
        .NUM_CLIENTS (NUM_CLIENTS),
        .IDX_W       (IDX_W)
    ) u_pick (
        .req_in     (bus.REQ),
        .last_grant (last_grant_q),
        .winner     (pick_idx),
        .valid      (pick_valid)
    );

    function automatic logic [NUM_CLIENTS-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_CLIENTS-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (idx == IDX_W'(i)) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

    // Route the winning client's op/index/data fields onto one set of wires
    always_comb begin
        pick_op    = 2'b00;
        pick_index = 3'd0;
        pick_data  = 4'd0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (pick_idx == IDX_W'(i)) begin
                pick_op    = bus.REQ_OP[2*i +: 2];
                pick_index = bus.REQ_INDEX[3*i +: 3];
                pick_data  = bus.REQ_DATA[4*i +: 4];
            end
        end
    end

`ifdef TM1638_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

    // Watchdog restarts while idle and advances while the driver owns the transaction
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (state_q == ST_ISSUE || state_q == ST_WAIT) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end else begin
            tmo_cnt_d = '0;
        end
    end

    // Watchdog counter register
    always_ff @(posedge CLK_IN) begin
        if (!RST_IN) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    assign timeout_hit = (state_q == ST_ISSUE || state_q == ST_WAIT) &&
                         (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // Next-state and output logic for the grant / strobe / wait / ack sequence
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        winner_d     = winner_q;
        op_d         = op_q;
        seg_index_d  = seg_index_q;
        seg_data_d   = seg_data_q;
        strobe_d     = strobe_q;
        ack_d        = '0;
        err_d        = 1'b0;
        rd_data_d    = rd_data_q;

        unique case (state_q)
            ST_IDLE: begin
                if (pick_valid && bus.READY) begin
                    winner_d    = pick_idx;
                    op_d        = op_e'(pick_op);
                    seg_index_d = pick_index;
                    seg_data_d  = pick_data;
                    if (op_e'(pick_op) == OP_RSVD) begin
                        // Nothing to send: complete immediately with an error flag
                        ack_d   = idx_to_onehot(pick_idx);
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        strobe_d = op_to_strobe(op_e'(pick_op));
                        state_d  = ST_ISSUE;
                    end
                end
            end

            ST_ISSUE: begin
                if (timeout_hit) begin
                    strobe_d     = STB_NONE;
                    ack_d        = idx_to_onehot(winner_q);
                    err_d        = 1'b1;
                    last_grant_d = winner_q;
                    state_d      = ST_IDLE;
                end else if (!bus.READY) begin
                    // Driver has accepted the command
                    strobe_d = STB_NONE;
                    state_d  = ST_WAIT;
                end
            end

            ST_WAIT: begin
                // A finished driver wins over a watchdog expiring on the same cycle
                if (bus.READY) begin
                    ack_d   = idx_to_onehot(winner_q);
                    state_d = ST_DONE;
                    if (op_q == OP_RD_BTN) begin
                        rd_data_d = bus.BUTTONS;
                    end
                end else if (timeout_hit) begin
                    ack_d        = idx_to_onehot(winner_q);
                    err_d        = 1'b1;
                    last_grant_d = winner_q;
                    state_d      = ST_IDLE;
                end
            end

            ST_DONE: begin
                last_grant_d = winner_q;
                state_d      = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any transaction without an ACK
    always_ff @(posedge CLK_IN) begin
        if (!RST_IN) begin
            state_q      <= ST_IDLE;
            last_grant_q <= LAST_RESET;
            winner_q     <= '0;
            op_q         <= OP_WR_SEG;
            seg_index_q  <= '0;
            seg_data_q   <= '0;
            strobe_q     <= STB_NONE;
            ack_q        <= '0;
            err_q        <= 1'b0;
            rd_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            winner_q     <= winner_d;
            op_q         <= op_d;
            seg_index_q  <= seg_index_d;
            seg_data_q   <= seg_data_d;
            strobe_q     <= strobe_d;
            ack_q        <= ack_d;
            err_q        <= err_d;
            rd_data_q    <= rd_data_d;
        end
    end

    assign bus.WRITE_SEG   = strobe_q[0];
    assign bus.WRITE_LED   = strobe_q[1];
    assign bus.READ_BUTTON = strobe_q[2];
    assign bus.SEG_INDEX   = seg_index_q;
    assign bus.SEG_DATA    = seg_data_q;
    assign bus.ACK         = ack_q;
    assign bus.ERR         = err_q;
    assign bus.RD_DATA     = rd_data_q;
    assign bus.BUSY        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_tm1638_arbiter.sv
// tb/tb_tm1638_arbiter.sv - self-checking bench for tm1638_arbiter (vector table + scoreboard)
module tb_tm1638_arbiter;

    localparam int N   = 4;
    localparam int TMO = 16;
    localparam int NV  = 6;

    logic clk = 1'b0;
    logic rstn;

    always #5 clk = ~clk;

    tm1638_arbiter_if #(.NUM_CLIENTS(N)) bus ();

    tm1638_arbiter #(
        .NUM_CLIENTS    (N),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .CLK_IN (clk),
        .RST_IN (rstn),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // ---------------- driver model ----------------
    int         drv_busy    = 1;
    bit         drv_hang    = 1'b0;
    bit         drv_hold    = 1'b0;
    int         drv_cnt     = 0;
    logic [7:0] drv_buttons = 8'h00;

    assign bus.BUTTONS = drv_buttons;

    always @(negedge clk) begin
        if (!rstn) begin
            bus.READY = 1'b1;
            drv_cnt   = 0;
        end else if (drv_hold) begin
            bus.READY = 1'b0;
        end else if (bus.READY && (bus.WRITE_SEG || bus.WRITE_LED || bus.READ_BUTTON)) begin
            bus.READY = 1'b0;
            drv_cnt   = drv_busy;
        end else if (!bus.READY && !drv_hang) begin
            if (drv_cnt <= 1) bus.READY = 1'b1;
            else drv_cnt--;
        end
    end

    // ---------------- monitor + scoreboard ----------------
    typedef struct {
        int         client;
        bit         err;
        logic [7:0] rd;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       sb_e;
    int         stb_pulses = 0;
    int         multi_stb  = 0;
    int         unstable   = 0;
    logic [2:0] stb_now;
    logic [2:0] prev_stb   = 3'b000;
    logic [2:0] stb_seen   = 3'b000;
    logic [2:0] cap_index  = 3'd0;
    logic [3:0] cap_data   = 4'd0;
    bit         in_txn     = 1'b0;

    always @(negedge clk) begin
        if (!rstn) begin
            in_txn   = 1'b0;
            prev_stb = 3'b000;
        end else begin
            stb_now = {bus.READ_BUTTON, bus.WRITE_LED, bus.WRITE_SEG};
            if ($countones(stb_now) > 1) multi_stb++;
            if (stb_now != 3'b000 && prev_stb == 3'b000) begin
                stb_pulses++;
                stb_seen  = stb_now;
                cap_index = bus.SEG_INDEX;
                cap_data  = bus.SEG_DATA;
                in_txn    = 1'b1;
            end else if (in_txn && (bus.SEG_INDEX != cap_index || bus.SEG_DATA != cap_data)) begin
                unstable++;
            end
            if (bus.ACK != '0) begin
                in_txn = 1'b0;
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_ack", 32'(bus.ACK), 32'h0);
                end else begin
                    sb_e = sb_q.pop_front();
                    check("sb_ack", 32'(bus.ACK), 32'(1 << sb_e.client));
                    check("sb_err", 32'(bus.ERR), 32'(sb_e.err));
                    check("sb_rd_data", 32'(bus.RD_DATA), 32'(sb_e.rd));
                end
            end else if (bus.ERR) begin
                check("err_without_ack", 32'(bus.ERR), 32'h0);
            end
            prev_stb = stb_now;
        end
    end

    // ---------------- helpers ----------------
    task automatic wait_ack(input int max_cyc, output int waited, output bit ok);
        ok     = 1'b0;
        waited = 0;
        while (!ok && waited < max_cyc) begin
            @(negedge clk);
            waited++;
            if (bus.ACK != '0) ok = 1'b1;
        end
    endtask

    function automatic int ack_idx(input logic [N-1:0] a);
        for (int i = 0; i < N; i++) if (a[i]) return i;
        return -1;
    endfunction

    task automatic set_client(input int c, input logic [1:0] op, input logic [2:0] idx, input logic [3:0] data);
        bus.REQ_OP[2*c +: 2]    = op;
        bus.REQ_INDEX[3*c +: 3] = idx;
        bus.REQ_DATA[4*c +: 4]  = data;
    endtask

    typedef struct {
        int         client;
        logic [1:0] op;
        logic [2:0] idx;
        logic [3:0] data;
        logic [7:0] btn;
        int         busy;
        logic [2:0] exp_stb;
        bit         exp_err;
    } vec_t;

    vec_t       vecs[NV];
    logic [7:0] model_rd;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   waited;
        bit   ok;
        int   p0;
        int   who;
        vec_t v;

        vecs[0] = '{2, 2'b00, 3'd5, 4'hA, 8'h00, 3, 3'b001, 1'b0};
        vecs[1] = '{1, 2'b10, 3'd0, 4'h0, 8'h5C, 2, 3'b100, 1'b0};
        vecs[2] = '{3, 2'b11, 3'd1, 4'h3, 8'h5C, 1, 3'b000, 1'b1};
        vecs[3] = '{0, 2'b01, 3'd7, 4'h1, 8'h5C, 1, 3'b010, 1'b0};
        vecs[4] = '{3, 2'b00, 3'd0, 4'hF, 8'h5C, 4, 3'b001, 1'b0};
        vecs[5] = '{1, 2'b10, 3'd2, 4'h0, 8'hA3, 1, 3'b100, 1'b0};

        rstn          = 1'b0;
        bus.REQ       = '0;
        bus.REQ_OP    = '0;
        bus.REQ_INDEX = '0;
        bus.REQ_DATA  = '0;
        model_rd      = 8'h00;

        // ---- reset values ----
        repeat (3) @(negedge clk);
        check("rst_strobes", 32'({bus.READ_BUTTON, bus.WRITE_LED, bus.WRITE_SEG}), 32'h0);
        check("rst_ack", 32'(bus.ACK), 32'h0);
        check("rst_err", 32'(bus.ERR), 32'h0);
        check("rst_busy", 32'(bus.BUSY), 32'h0);
        check("rst_rd_data", 32'(bus.RD_DATA), 32'h0);
        check("rst_seg_index", 32'(bus.SEG_INDEX), 32'h0);
        check("rst_seg_data", 32'(bus.SEG_DATA), 32'h0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // ---- table-driven single transactions ----
        for (int i = 0; i < NV; i++) begin
            v           = vecs[i];
            drv_busy    = v.busy;
            drv_buttons = v.btn;
            if (v.op == 2'b10) model_rd = v.btn;
            set_client(v.client, v.op, v.idx, v.data);
            sb_q.push_back('{v.client, v.exp_err, model_rd});
            p0 = stb_pulses;
            bus.REQ[v.client] = 1'b1;
            wait_ack(60, waited, ok);
            bus.REQ[v.client] = 1'b0;
            check($sformatf("v%0d_ack_seen", i), 32'(ok), 32'h1);
            check($sformatf("v%0d_latency", i), 32'(waited), (v.exp_stb == 3'b000) ? 32'd1 : 32'(v.busy + 2));
            check($sformatf("v%0d_strobe_pulses", i), 32'(stb_pulses - p0), (v.exp_stb == 3'b000) ? 32'd0 : 32'd1);
            if (v.exp_stb != 3'b000) begin
                check($sformatf("v%0d_strobe_kind", i), 32'(stb_seen), 32'(v.exp_stb));
                check($sformatf("v%0d_seg_index", i), 32'(cap_index), 32'(v.idx));
                check($sformatf("v%0d_seg_data", i), 32'(cap_data), 32'(v.data));
            end
            @(negedge clk);
            check($sformatf("v%0d_busy_after", i), 32'(bus.BUSY), 32'h0);
            check($sformatf("v%0d_ack_one_cycle", i), 32'(bus.ACK), 32'h0);
            @(negedge clk);
        end

        // ---- READY low while requesting ----
        drv_hold = 1'b1;
        drv_busy = 1;
        repeat (2) @(negedge clk);
        set_client(0, 2'b01, 3'd2, 4'h1);
        sb_q.push_back('{0, 1'b0, model_rd});
        p0 = stb_pulses;
        bus.REQ[0] = 1'b1;
        repeat (10) @(negedge clk);
        check("rdylow_no_strobe", 32'(stb_pulses - p0), 32'd0);
        check("rdylow_not_busy", 32'(bus.BUSY), 32'h0);
        drv_hold = 1'b0;
        wait_ack(60, waited, ok);
        bus.REQ[0] = 1'b0;
        check("rdylow_ack_seen", 32'(ok), 32'h1);
        check("rdylow_strobe_pulses", 32'(stb_pulses - p0), 32'd1);
        repeat (2) @(negedge clk);

        // ---- fairness: everyone requesting, rotation from client 0 after reset ----
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn     = 1'b1;
        model_rd = 8'h00;
        for (int c = 0; c < N; c++) set_client(c, 2'b00, 3'(c), 4'(c + 8));
        for (int k = 0; k < 8; k++) sb_q.push_back('{k % N, 1'b0, model_rd});
        bus.REQ = '1;
        for (int k = 0; k < 8; k++) begin
            wait_ack(60, waited, ok);
            who = ack_idx(bus.ACK);
            check($sformatf("fair_ack_seen_%0d", k), 32'(ok), 32'h1);
            check($sformatf("fair_grant_%0d", k), 32'(who), 32'(k % N));
            check($sformatf("fair_seg_index_%0d", k), 32'(cap_index), 32'(k % N));
            if (k == 7 || who < 0) begin
                bus.REQ = '0;
            end else begin
                bus.REQ[who] = 1'b0;
                @(negedge clk);
                bus.REQ[who] = 1'b1;
            end
        end
        repeat (3) @(negedge clk);

        // ---- reset while in WAIT ----
        drv_busy = 20;
        set_client(2, 2'b00, 3'd3, 4'h6);
        p0 = stb_pulses;
        bus.REQ[2] = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 30 && !ok; t++) begin
            @(negedge clk);
            if (stb_pulses != p0 && bus.BUSY && !bus.WRITE_SEG) ok = 1'b1;
        end
        check("rstwait_reached_wait", 32'(ok), 32'h1);
        rstn = 1'b0;
        @(negedge clk);
        check("rstwait_strobes", 32'({bus.READ_BUTTON, bus.WRITE_LED, bus.WRITE_SEG}), 32'h0);
        check("rstwait_ack", 32'(bus.ACK), 32'h0);
        check("rstwait_busy", 32'(bus.BUSY), 32'h0);
        drv_busy = 1;
        model_rd = 8'h00;
        set_client(0, 2'b01, 3'd4, 4'h1);
        sb_q.push_back('{0, 1'b0, model_rd});
        sb_q.push_back('{2, 1'b0, model_rd});
        rstn       = 1'b1;
        bus.REQ[0] = 1'b1;
        wait_ack(60, waited, ok);
        check("rstwait_first_grant", 32'(ack_idx(bus.ACK)), 32'd0);
        bus.REQ[0] = 1'b0;
        wait_ack(60, waited, ok);
        check("rstwait_second_grant", 32'(ack_idx(bus.ACK)), 32'd2);
        bus.REQ[2] = 1'b0;
        repeat (2) @(negedge clk);

`ifdef TM1638_ARB_TIMEOUT_EN
        // ---- watchdog abort with READY stuck low ----
        drv_hang = 1'b1;
        set_client(1, 2'b10, 3'd0, 4'h0);
        sb_q.push_back('{1, 1'b1, model_rd});
        bus.REQ[1] = 1'b1;
        wait_ack(60, waited, ok);
        bus.REQ[1] = 1'b0;
        check("tmo_ack_seen", 32'(ok), 32'h1);
        check("tmo_latency", 32'(waited), 32'(TMO + 1));
        check("tmo_strobe_low", 32'({bus.READ_BUTTON, bus.WRITE_LED, bus.WRITE_SEG}), 32'h0);
        drv_hang = 1'b0;
        repeat (3) @(negedge clk);
        check("tmo_busy_after", 32'(bus.BUSY), 32'h0);
`endif

        check("sb_empty", 32'(sb_q.size()), 32'h0);
        check("one_strobe_at_a_time", 32'(multi_stb), 32'h0);
        check("seg_fields_stable", 32'(unstable), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
